// File: rtl/evt2_pkg.sv
// rtl/evt2_pkg.sv - EVT 2.0 word types, field positions and decoded event record
package evt2_pkg;

  localparam int TS_W        = 34;
  localparam int COORD_W     = 14;
  localparam int RAW_COORD_W = 11;
  localparam int TH_W        = 28;
  localparam int TS_LSB_W    = 6;

  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 28;
  localparam int TS_HI   = 27;
  localparam int TS_LO   = 22;
  localparam int X_HI    = 21;
  localparam int X_LO    = 11;
  localparam int Y_HI    = 10;
  localparam int Y_LO    = 0;
  localparam int TH_HI   = 27;
  localparam int TH_LO   = 0;

  typedef enum logic [3:0] {
    CD_OFF      = 4'h0,
    CD_ON       = 4'h1,
    TIME_HIGH   = 4'h8,
    EXT_TRIGGER = 4'hA
  } evt_type_e;

  typedef struct packed {
    logic [TS_W-1:0]    timestamp;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               pol;
  } cd_event_t;

endpackage

// File: rtl/evt2_sat_counter.sv
// rtl/evt2_sat_counter.sv - saturating event counter with synchronous clear
module evt2_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // clear has priority over a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/evt2_decoder.sv
// rtl/evt2_decoder.sv - EVT 2.0 stream decoder with crop window; EVT_DECODER_STATS_EN adds counters
module evt2_decoder
  import evt2_pkg::*;
#(
  parameter int unsigned X_OFFSET = 576,
  parameter int unsigned Y_OFFSET = 296,
  parameter int unsigned CROP_W   = 128,
  parameter int unsigned CROP_H   = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [TS_W-1:0]    timestamp,
  output logic [COORD_W-1:0] x_coord,
  output logic [COORD_W-1:0] y_coord,
  output logic               polarity,
  output logic               is_valid,
  output logic               synced,
`ifdef EVT_DECODER_STATS_EN
  input  logic               stats_clear,
  output logic [31:0]        cnt_emitted,
  output logic [31:0]        cnt_dropped,
  output logic [31:0]        cnt_time_high,
  output logic [31:0]        cnt_other,
`endif
  output logic               ts_error
);

  typedef enum logic {WAIT_TH, RUN} state_e;

  localparam logic [RAW_COORD_W-1:0] X_BASE = RAW_COORD_W'(X_OFFSET);
  localparam logic [RAW_COORD_W-1:0] Y_BASE = RAW_COORD_W'(Y_OFFSET);
  localparam logic [RAW_COORD_W:0]   X_LIM  = (RAW_COORD_W+1)'(X_OFFSET + CROP_W);
  localparam logic [RAW_COORD_W:0]   Y_LIM  = (RAW_COORD_W+1)'(Y_OFFSET + CROP_H);

  state_e                 state_q, state_d;
  logic [TH_W-1:0]        time_high;
  cd_event_t              ev_q, ev_d;

  evt_type_e              in_type;
  logic [TS_LSB_W-1:0]    in_ts;
  logic [RAW_COORD_W-1:0] in_x, in_y, x_rel, y_rel;
  logic [TH_W-1:0]        in_th;
  logic                   accept, in_win;
  logic                   is_cd, is_th, is_other, emit, drop, th_back;

  assign accept  = in_valid & in_ready;
  assign in_type = evt_type_e'(in_data[TYPE_HI:TYPE_LO]);
  assign in_ts   = in_data[TS_HI:TS_LO];
  assign in_x    = in_data[X_HI:X_LO];
  assign in_y    = in_data[Y_HI:Y_LO];
  assign in_th   = in_data[TH_HI:TH_LO];
  assign x_rel   = in_x - X_BASE;
  assign y_rel   = in_y - Y_BASE;

  // one extra bit on the compares so X_OFFSET+CROP_W cannot overflow
  assign in_win = ({1'b0, in_x} >= {1'b0, X_BASE}) && ({1'b0, in_x} < X_LIM) &&
                  ({1'b0, in_y} >= {1'b0, Y_BASE}) && ({1'b0, in_y} < Y_LIM);

  always_comb begin
    state_d  = state_q;
    is_cd    = 1'b0;
    is_th    = 1'b0;
    is_other = 1'b0;
    th_back  = 1'b0;
    if (accept) begin
      case (in_type)
        CD_OFF, CD_ON: is_cd    = 1'b1;
        TIME_HIGH:     is_th    = 1'b1;
        default:       is_other = 1'b1;
      endcase
    end
    emit = is_cd && (state_q == RUN) && in_win;
    drop = is_cd && !emit;
    if (is_th) begin
      state_d = RUN;
      // 0xFFFFFFF -> 0 is a counter wrap, not a step backwards
      th_back = (in_th < time_high) && !((time_high == {TH_W{1'b1}}) && (in_th == '0));
    end
    ev_d.timestamp = {time_high, in_ts};
    ev_d.x         = {{(COORD_W-RAW_COORD_W){1'b0}}, x_rel};
    ev_d.y         = {{(COORD_W-RAW_COORD_W){1'b0}}, y_rel};
    ev_d.pol       = (in_type == CD_ON);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_TH;
      in_ready  <= 1'b0;
      time_high <= '0;
      synced    <= 1'b0;
      ts_error  <= 1'b0;
      is_valid  <= 1'b0;
      ev_q      <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= 1'b1;
      is_valid <= emit;
      if (emit) begin
        ev_q <= ev_d;
      end
      if (is_th) begin
        time_high <= in_th;
        synced    <= 1'b1;
        if (th_back) begin
          ts_error <= 1'b1;
        end
      end
    end
  end

  assign timestamp = ev_q.timestamp;
  assign x_coord   = ev_q.x;
  assign y_coord   = ev_q.y;
  assign polarity  = ev_q.pol;

`ifdef EVT_DECODER_STATS_EN
  evt2_sat_counter #(.W(32)) u_cnt_emitted (
    .clk(clk), .reset(reset), .clear(stats_clear), .inc(emit), .count(cnt_emitted)
  );
  evt2_sat_counter #(.W(32)) u_cnt_dropped (
    .clk(clk), .reset(reset), .clear(stats_clear), .inc(drop), .count(cnt_dropped)
  );
  evt2_sat_counter #(.W(32)) u_cnt_time_high (
    .clk(clk), .reset(reset), .clear(stats_clear), .inc(is_th), .count(cnt_time_high)
  );
  evt2_sat_counter #(.W(32)) u_cnt_other (
    .clk(clk), .reset(reset), .clear(stats_clear), .inc(is_other), .count(cnt_other)
  );
`endif

endmodule

// File: tb/tb_evt2_decoder.sv
// tb/tb_evt2_decoder.sv - scoreboard bench for evt2_decoder
module tb_evt2_decoder;

  logic        clk, reset;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [33:0] timestamp;
  logic [13:0] x_coord, y_coord;
  logic        polarity, is_valid, synced, ts_error;
`ifdef EVT_DECODER_STATS_EN
  logic        stats_clear;
  logic [31:0] cnt_emitted, cnt_dropped, cnt_time_high, cnt_other;
`endif

  evt2_decoder dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .timestamp(timestamp), .x_coord(x_coord), .y_coord(y_coord), .polarity(polarity),
    .is_valid(is_valid), .synced(synced),
`ifdef EVT_DECODER_STATS_EN
    .stats_clear(stats_clear), .cnt_emitted(cnt_emitted), .cnt_dropped(cnt_dropped),
    .cnt_time_high(cnt_time_high), .cnt_other(cnt_other),
`endif
    .ts_error(ts_error)
  );

  typedef struct {
    logic [33:0] ts;
    logic [13:0] x;
    logic [13:0] y;
    logic        pol;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] cd(input logic pol, input logic [5:0] ts,
                                     input logic [10:0] x, input logic [10:0] y);
    return {3'b000, pol, ts, x, y};
  endfunction

  function automatic logic [31:0] th(input logic [27:0] v);
    return {4'h8, v};
  endfunction

  task automatic expect_ev(input logic [33:0] ts, input logic [13:0] x,
                           input logic [13:0] y, input logic pol);
    exp_t e;
    e.ts = ts; e.x = x; e.y = y; e.pol = pol;
    q.push_back(e);
  endtask

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // monitor: every is_valid strobe must match the oldest expected event
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (is_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got ts=0x%0h x=%0d y=%0d expected none", timestamp, x_coord, y_coord);
        end else begin
          e = q.pop_front();
          chk("ev_timestamp", 64'(timestamp), 64'(e.ts));
          chk("ev_x", 64'(x_coord), 64'(e.x));
          chk("ev_y", 64'(y_coord), 64'(e.y));
          chk("ev_pol", 64'(polarity), 64'(e.pol));
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef EVT_DECODER_STATS_EN
    stats_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_outputs", {timestamp, x_coord, y_coord, polarity, is_valid, synced, ts_error}, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1 chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("in_ready_after_edge", 64'(in_ready), 64'd1);

    // pre-sync CD is dropped, then sync and repeat it
    send(cd(1'b1, 6'd5, 11'd579, 11'd303));
    idle(2);
    chk("synced_pre", 64'(synced), 64'd0);
    send(th(28'h0000010));
    idle(1);
    chk("synced_post", 64'(synced), 64'd1);
    chk("ts_error_first_th", 64'(ts_error), 64'd0);
    send(cd(1'b1, 6'd5, 11'd579, 11'd303));
    expect_ev(34'h405, 14'd3, 14'd7, 1'b1);
    idle(2);

    // crop edges in x then y
    send(cd(1'b0, 6'd0, 11'd575, 11'd296));
    send(cd(1'b0, 6'd0, 11'd576, 11'd296)); expect_ev(34'h400, 14'd0, 14'd0, 1'b0);
    send(cd(1'b0, 6'd0, 11'd703, 11'd296)); expect_ev(34'h400, 14'd127, 14'd0, 1'b0);
    send(cd(1'b0, 6'd0, 11'd704, 11'd296));
    send(cd(1'b1, 6'd1, 11'd600, 11'd295));
    send(cd(1'b1, 6'd1, 11'd600, 11'd423)); expect_ev(34'h401, 14'd24, 14'd127, 1'b1);
    send(cd(1'b1, 6'd1, 11'd600, 11'd424));
    idle(2);

    // 8-word burst at full rate
    for (int i = 0; i < 8; i++) begin
      send(cd(1'(i), 6'(i + 10), 11'(576 + i * 9), 11'(296 + i * 5)));
      expect_ev({28'h10, 6'(i + 10)}, 14'(i * 9), 14'(i * 5), 1'(i));
      chk("burst_in_ready", 64'(in_ready), 64'd1);
    end
    idle(2);

    // backwards TIME_HIGH is sticky and still adopted
    send(th(28'h100));
    send(th(28'h0FF));
    idle(1);
    chk("ts_error_back", 64'(ts_error), 64'd1);
    send(cd(1'b0, 6'd0, 11'd576, 11'd296)); expect_ev(34'h3FC0, 14'd0, 14'd0, 1'b0);
    send(th(28'h200));
    idle(2);
    chk("ts_error_sticky", 64'(ts_error), 64'd1);

    // asynchronous reset mid-burst
    send(cd(1'b1, 6'd1, 11'd580, 11'd300)); expect_ev({28'h200, 6'd1}, 14'd4, 14'd4, 1'b1);
    send(cd(1'b1, 6'd2, 11'd581, 11'd300)); expect_ev({28'h200, 6'd2}, 14'd5, 14'd4, 1'b1);
    send(cd(1'b1, 6'd3, 11'd582, 11'd300));
    @(posedge clk);
    #2 reset = 1'b1;
    q.delete();
    #1;
    chk("async_rst_outputs", {timestamp, x_coord, y_coord, polarity, is_valid, synced, ts_error}, 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    in_data  = cd(1'b1, 6'd4, 11'd583, 11'd300);
    in_valid = 1'b1;
    chk("rel_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("rel_in_ready_1", 64'(in_ready), 64'd1);
    idle(2);
    chk("rst_synced", 64'(synced), 64'd0);

    // wrap and equal TIME_HIGH are legal
    send(th(28'hFFFFFFF));
    send(th(28'h0000000));
    send(cd(1'b0, 6'd3, 11'd600, 11'd300)); expect_ev(34'h3, 14'd24, 14'd4, 1'b0);
    send(th(28'h0000000));
    idle(2);
    chk("ts_error_wrap", 64'(ts_error), 64'd0);

    // non-CD words are consumed silently
`ifdef EVT_DECODER_STATS_EN
    @(negedge clk); stats_clear = 1'b1;
    @(negedge clk); stats_clear = 1'b0;
`endif
    send(32'hA0000001);
    send(cd(1'b1, 6'd1, 11'd580, 11'd300)); expect_ev(34'h1, 14'd4, 14'd4, 1'b1);
    send(32'hF0000000);
    send(cd(1'b0, 6'd2, 11'd581, 11'd301)); expect_ev(34'h2, 14'd5, 14'd5, 1'b0);
    send(cd(1'b0, 6'd2, 11'd10, 11'd10));
    idle(2);
`ifdef EVT_DECODER_STATS_EN
    chk("cnt_other", 64'(cnt_other), 64'd2);
    chk("cnt_emitted", 64'(cnt_emitted), 64'd2);
    chk("cnt_dropped", 64'(cnt_dropped), 64'd1);
    chk("cnt_time_high", 64'(cnt_time_high), 64'd0);
    send(cd(1'b1, 6'd7, 11'd590, 11'd310)); expect_ev(34'h7, 14'd14, 14'd14, 1'b1);
    stats_clear = 1'b1;
    idle(1);
    stats_clear = 1'b0;
    chk("cnt_emitted_clear", 64'(cnt_emitted), 64'd0);
    idle(1);
`endif

    idle(3);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
